// File: rtl/rrarb_lock.sv
// Round-robin arbiter with locked multi-beat grants. The grant is held until the owner transfers its last beat.
// The optional stall timeout is enabled by defining RRARB_LOCK_TIMEOUT_EN.

// Cyclic first-set search: finds the first set bit at or above i_target, wrapping round to bit 0.
module fxcs #(
    parameter int WIDTH          = 8,
    parameter int ABSTRACT_MODEL = 0
) (
    input  logic [WIDTH-1:0]         i_vector,
    input  logic [$clog2(WIDTH)-1:0] i_target,
    output logic                     o_valid,
    output logic [$clog2(WIDTH)-1:0] o_index
);
    localparam int IW = $clog2(WIDTH);

    assign o_valid = |i_vector;

    generate
        if (ABSTRACT_MODEL != 0) begin : g_model
            // Walk the rotation from its far end so the nearest set bit is written last
            always_comb begin
                o_index = {IW{1'b0}};
                for (int k = WIDTH - 1; k >= 0; k--) begin
                    if (i_vector[(int'(i_target) + k) % WIDTH]) begin
                        o_index = IW'((int'(i_target) + k) % WIDTH);
                    end else begin
                        o_index = o_index;
                    end
                end
            end
        end else begin : g_struct
            logic [2*WIDTH-1:0] dbl_s;
            logic [WIDTH-1:0]   rot_s;
            logic [IW-1:0]      off_s;
            logic [IW:0]        sum_s;

            // Rotate so that i_target lands on bit 0
            assign dbl_s = {i_vector, i_vector} >> i_target;
            assign rot_s = dbl_s[WIDTH-1:0];

            // Lowest-set-bit priority encoder over the rotated vector
            always_comb begin
                off_s = {IW{1'b0}};
                for (int k = WIDTH - 1; k >= 0; k--) begin
                    if (rot_s[k]) begin
                        off_s = IW'(k);
                    end else begin
                        off_s = off_s;
                    end
                end
            end

            // Undo the rotation with a modulo-WIDTH add
            always_comb begin
                sum_s = {1'b0, i_target} + {1'b0, off_s};
                if (sum_s >= (IW+1)'(WIDTH)) begin
                    o_index = IW'(sum_s - (IW+1)'(WIDTH));
                end else begin
                    o_index = sum_s[IW-1:0];
                end
            end
        end
    endgenerate
endmodule

module rrarb_lock #(
    parameter int N_REQ          = 8,
    parameter int ABSTRACT_MODEL = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_last,
    input  logic                     i_ready,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_gntIdx,
    output logic                     o_busy,
    output logic                     o_beat,
    output logic                     o_timeout
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r, state_n;
    logic [IW-1:0]    ptr_r, ptr_n;
    logic [N_REQ-1:0] gnt_r, gnt_n;
    logic [IW-1:0]    gnt_idx_r, gnt_idx_n;
    logic             busy_r, busy_n;
    logic             win_valid_s;
    logic [IW-1:0]    win_idx_s;
    logic             beat_s;

`ifdef RRARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] stall_r, stall_n;
    logic          timeout_r, timeout_n;
`endif

    // Priority moves to the requester just after the one being released
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        if (g == IW'(N_REQ - 1)) begin
            next_ptr = {IW{1'b0}};
        end else begin
            next_ptr = g + IW'(1);
        end
    endfunction

    fxcs #(
        .WIDTH          (N_REQ),
        .ABSTRACT_MODEL (ABSTRACT_MODEL)
    ) u_fxcs (
        .i_vector (i_req),
        .i_target (ptr_r),
        .o_valid  (win_valid_s),
        .o_index  (win_idx_s)
    );

    assign beat_s = busy_r & i_req[gnt_idx_r] & i_ready;

    // Next-state logic: grant from IDLE, release on last beat (or stall timeout)
    always_comb begin
        state_n   = state_r;
        ptr_n     = ptr_r;
        gnt_n     = gnt_r;
        gnt_idx_n = gnt_idx_r;
        busy_n    = busy_r;
`ifdef RRARB_LOCK_TIMEOUT_EN
        stall_n   = stall_r;
        timeout_n = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_n   = ST_LOCKED;
                    gnt_n     = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                    gnt_idx_n = win_idx_s;
                    busy_n    = 1'b1;
`ifdef RRARB_LOCK_TIMEOUT_EN
                    stall_n   = {CW{1'b0}};
`endif
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (beat_s) begin
`ifdef RRARB_LOCK_TIMEOUT_EN
                    stall_n = {CW{1'b0}};
`endif
                    if (i_last[gnt_idx_r]) begin
                        state_n   = ST_IDLE;
                        gnt_n     = {N_REQ{1'b0}};
                        gnt_idx_n = {IW{1'b0}};
                        busy_n    = 1'b0;
                        ptr_n     = next_ptr(gnt_idx_r);
                    end else begin
                        state_n = ST_LOCKED;
                    end
                end
`ifdef RRARB_LOCK_TIMEOUT_EN
                // This stall cycle is the TIMEOUT_CYCLES-th in a row
                else if (stall_r == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_n   = ST_IDLE;
                    gnt_n     = {N_REQ{1'b0}};
                    gnt_idx_n = {IW{1'b0}};
                    busy_n    = 1'b0;
                    ptr_n     = next_ptr(gnt_idx_r);
                    stall_n   = {CW{1'b0}};
                    timeout_n = 1'b1;
                end else begin
                    stall_n = stall_r + CW'(1);
                end
`else
                else begin
                    state_n = ST_LOCKED;
                end
`endif
            end
            default: begin
                state_n   = ST_IDLE;
                gnt_n     = {N_REQ{1'b0}};
                gnt_idx_n = {IW{1'b0}};
                busy_n    = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {IW{1'b0}};
            gnt_r     <= {N_REQ{1'b0}};
            gnt_idx_r <= {IW{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            ptr_r     <= ptr_n;
            gnt_r     <= gnt_n;
            gnt_idx_r <= gnt_idx_n;
            busy_r    <= busy_n;
        end
    end

`ifdef RRARB_LOCK_TIMEOUT_EN
    // Stall counter and release pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_r   <= {CW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            stall_r   <= stall_n;
            timeout_r <= timeout_n;
        end
    end

    assign o_timeout = timeout_r;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_gnt    = gnt_r;
    assign o_gntIdx = gnt_idx_r;
    assign o_busy   = busy_r;
    assign o_beat   = beat_s;
endmodule
